mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the CPU data-memory bus, next to data_memory.
//  The CPU writes bytes with sw; the block buffers them in a FIFO and serialises them as 8N1 on uart_tx.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/mmio_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
// Holds the TX FSM state encoding, register offsets and STATUS bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;
    localparam logic [31:0] BAUD_OFS   = 32'd8;

    localparam int ST_BUSY   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_EMPTY  = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head data; pop is visible on the next edge.
// A push while full is dropped unless a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// 8N1 UART transmitter behind a 3-register MMIO window; line falls one edge after a push into an empty FIFO.
// Reads are combinational; pushes into a full FIFO are dropped and flagged in a sticky overflow bit.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0]      BASE_ADDR   = 32'h0000_1000,
    parameter int               FIFO_DEPTH  = 8,
    parameter int               DIV_W       = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(9)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        uart_tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             sel_tx, sel_st, sel_bd;
    logic             wr_tx, wr_st, wr_bd;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_head;
    logic [CW-1:0]    fifo_count;
    logic             overflow_q;
    logic [DIV_W-1:0] baud_div_q;
    logic [3:0]       cnt4;
    logic [31:0]      status;

    tx_state_t        state_q, state_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    assign sel_tx = (addr == BASE_ADDR + TXDATA_OFS);
    assign sel_st = (addr == BASE_ADDR + STATUS_OFS);
    assign sel_bd = (addr == BASE_ADDR + BAUD_OFS);
    assign wr_tx  = mem_write && sel_tx;
    assign wr_st  = mem_write && sel_st;
    assign wr_bd  = mem_write && sel_bd;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_tx),
        .din   (write_data[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            baud_div_q <= DEFAULT_DIV;
        end else begin
            // A full FIFO that is popping this edge still has room for the push.
            if (wr_tx && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end else if (wr_st && write_data[ST_OVF]) begin
                overflow_q <= 1'b0;
            end
            if (wr_bd) begin
                baud_div_q <= write_data[DIV_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    div_d    = baud_div_q;
                    baud_d   = baud_div_q;
                    tx_d     = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                    baud_d  = div_q;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = div_q;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign uart_tx = tx_q;

    always_comb begin
        cnt4 = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);
    end

    assign status = {24'd0, cnt4, overflow_q, fifo_empty, fifo_full, (state_q != IDLE)};

    always_comb begin
        read_data = '0;
        if (mem_read) begin
            if (sel_st) begin
                read_data = status;
            end else if (sel_bd) begin
                read_data = 32'(baud_div_q);
            end
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, framing via a mid-bit sampling monitor, overflow and reset.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] A_TX = BASE + 32'd0;
    localparam logic [31:0] A_ST = BASE + 32'd4;
    localparam logic [31:0] A_BD = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        uart_tx;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mon_div = 9;
    logic [9:0] q_lv [$];
    int         q_fc [$];

    mmio_uart_tx dut (
        .clk        (clk),
        .rst        (rst),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: on a low level, sample each of the 10 bit cells at mid-bit; a reset abandons the frame.
    initial begin
        logic [9:0] lv;
        int fc, d, cur, target;
        bit ab;
        forever begin
            @(posedge clk);
            #1;
            if (uart_tx === 1'b0) begin
                fc = cyc; d = mon_div; cur = 0; ab = 0; lv = '1;
                for (int b = 0; b < 10; b++) begin
                    target = b * (d + 1) + (d + 1) / 2;
                    while (cur < target && !ab) begin
                        @(posedge clk);
                        cur++;
                        if (rst) ab = 1;
                    end
                    if (ab) break;
                    #1;
                    lv[b] = uart_tx;
                end
                if (!ab) begin
                    q_lv.push_back(lv);
                    q_fc.push_back(fc);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; write_data = d; mem_write = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0; addr = '0; write_data = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; mem_read = 1'b1;
        #1;
        d = read_data;
        mem_read = 1'b0; addr = '0;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (q_lv.size() >= n) begin
                ok = 1;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_line got=%b exp=1", uart_tx); end
        @(negedge clk);
        rst = 1'b0;
        bus_read(A_ST, r);
        total++;
        if (r !== 32'h04) begin bad++; $display("FAIL reset_status got=%h exp=%h", r, 32'h04); end
        bus_read(A_BD, r);
        total++;
        if (r !== 32'd9) begin bad++; $display("FAIL reset_baud got=%h exp=%h", r, 32'd9); end
    endtask

    task automatic test_single_frame();
        logic [31:0] r;
        logic [9:0] lv;
        int pc, fc;
        bit ok;
        bus_write(A_BD, 32'd3);
        mon_div = 3;
        bus_write(A_TX, 32'h55);
        pc = cyc;
        wait_frames(1, 100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL frame55_timeout got=%0d frames exp=1", q_lv.size()); end
        else begin
            lv = q_lv.pop_front(); fc = q_fc.pop_front();
            total++;
            if (fc - pc !== 1) begin bad++; $display("FAIL frame55_latency got=%0d exp=1", fc - pc); end
            total++;
            if (lv !== 10'b10_1010_1010) begin bad++; $display("FAIL frame55_levels got=%b exp=%b", lv, 10'b10_1010_1010); end
        end
        repeat (4) @(posedge clk);
        bus_read(A_ST, r);
        total++;
        if (r !== 32'h04) begin bad++; $display("FAIL frame55_idle_status got=%h exp=%h", r, 32'h04); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bytes [3];
        logic [31:0] st_exp [3];
        logic [31:0] r;
        logic [9:0]  lv;
        int fc, prev_fc;
        bit ok;
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF;
        // Sampled during each frame's stop bit: 2 then 1 then 0 bytes still queued.
        st_exp[0] = 32'h21; st_exp[1] = 32'h11; st_exp[2] = 32'h05;
        for (int i = 0; i < 3; i++) bus_write(A_TX, 32'(bytes[i]));
        bus_read(A_ST, r);
        total++;
        if (r !== 32'h21) begin bad++; $display("FAIL b2b_status_after_push got=%h exp=%h", r, 32'h21); end
        prev_fc = 0;
        for (int i = 0; i < 3; i++) begin
            wait_frames(1, 120, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL b2b_timeout frame=%0d got=0 exp=1", i); end
            else begin
                lv = q_lv.pop_front(); fc = q_fc.pop_front();
                total++;
                if (lv !== {1'b1, bytes[i], 1'b0}) begin
                    bad++; $display("FAIL b2b_levels frame=%0d got=%b exp=%b", i, lv, {1'b1, bytes[i], 1'b0});
                end
                if (i > 0) begin
                    total++;
                    if (fc - prev_fc !== 41) begin bad++; $display("FAIL b2b_gap frame=%0d got=%0d exp=41", i, fc - prev_fc); end
                end
                prev_fc = fc;
                bus_read(A_ST, r);
                total++;
                if (r !== st_exp[i]) begin bad++; $display("FAIL b2b_status frame=%0d got=%h exp=%h", i, r, st_exp[i]); end
            end
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic test_div_zero();
        logic [9:0] lv;
        int pc, fc0, fc1;
        bit ok;
        bus_write(A_BD, 32'd0);
        mon_div = 0;
        bus_write(A_TX, 32'h96);
        pc = cyc;
        bus_write(A_TX, 32'h01);
        wait_frames(2, 60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL div0_timeout got=%0d frames exp=2", q_lv.size()); end
        else begin
            lv = q_lv.pop_front(); fc0 = q_fc.pop_front();
            total++;
            if (lv !== {1'b1, 8'h96, 1'b0}) begin bad++; $display("FAIL div0_levels0 got=%b exp=%b", lv, {1'b1, 8'h96, 1'b0}); end
            total++;
            if (fc0 - pc !== 1) begin bad++; $display("FAIL div0_latency got=%0d exp=1", fc0 - pc); end
            lv = q_lv.pop_front(); fc1 = q_fc.pop_front();
            total++;
            if (lv !== {1'b1, 8'h01, 1'b0}) begin bad++; $display("FAIL div0_levels1 got=%b exp=%b", lv, {1'b1, 8'h01, 1'b0}); end
            total++;
            if (fc1 - fc0 !== 11) begin bad++; $display("FAIL div0_gap got=%0d exp=11", fc1 - fc0); end
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        bus_write(A_BD, 32'd1000);
        mon_div = 1000;
        bus_write(A_TX, 32'h11);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 9; i++) bus_write(A_TX, 32'(8'h20 + i));
        bus_read(A_ST, r);
        total++;
        if (r !== 32'h8B) begin bad++; $display("FAIL ovf_status got=%h exp=%h", r, 32'h8B); end
        bus_write(A_ST, 32'h07);
        bus_read(A_ST, r);
        total++;
        if (r !== 32'h8B) begin bad++; $display("FAIL ovf_keep got=%h exp=%h", r, 32'h8B); end
        bus_write(A_ST, 32'h08);
        bus_read(A_ST, r);
        total++;
        if (r !== 32'h83) begin bad++; $display("FAIL ovf_clear got=%h exp=%h", r, 32'h83); end
    endtask

    task automatic test_mid_frame_reset();
        logic [31:0] r;
        bit found;
        int lows;
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        mon_div = 9;
        bus_write(A_TX, 32'h0F);
        found = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (uart_tx === 1'b0) begin found = 1; break; end
        end
        total++;
        if (!found) begin bad++; $display("FAIL rst_frame_start got=none exp=fall"); end
        repeat (54) @(posedge clk);
        #1;
        total++;
        if (uart_tx !== 1'b0) begin bad++; $display("FAIL rst_mid_bit4 got=%b exp=0", uart_tx); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL rst_line_high got=%b exp=1", uart_tx); end
        @(negedge clk); rst = 1'b0;
        bus_read(A_ST, r);
        total++;
        if (r !== 32'h04) begin bad++; $display("FAIL rst_status got=%h exp=%h", r, 32'h04); end
        bus_read(A_BD, r);
        total++;
        if (r !== 32'd9) begin bad++; $display("FAIL rst_baud got=%h exp=%h", r, 32'd9); end
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1) lows++;
        end
        total++;
        if (lows !== 0 || q_lv.size() !== 0) begin
            bad++; $display("FAIL rst_no_frame got=%0d low cycles %0d frames exp=0", lows, q_lv.size());
        end
    endtask

    task automatic test_decode();
        logic [31:0] r;
        int lows;
        bus_read(BASE + 32'd12, r);
        total++;
        if (r !== 32'd0) begin bad++; $display("FAIL dec_read_unmapped got=%h exp=0", r); end
        bus_read(A_TX, r);
        total++;
        if (r !== 32'd0) begin bad++; $display("FAIL dec_read_txdata got=%h exp=0", r); end
        bus_write(BASE + 32'd12, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h1_0000, 32'h0000_00AA);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1) lows++;
        end
        total++;
        if (lows !== 0) begin bad++; $display("FAIL dec_line_quiet got=%0d exp=0", lows); end
        bus_read(A_ST, r);
        total++;
        if (r !== 32'h04) begin bad++; $display("FAIL dec_status got=%h exp=%h", r, 32'h04); end
        @(negedge clk);
        addr = A_ST; mem_read = 1'b0;
        #1;
        total++;
        if (read_data !== 32'd0) begin bad++; $display("FAIL dec_no_strobe got=%h exp=0", read_data); end
        addr = A_BD; write_data = 32'd5; mem_write = 1'b1; mem_read = 1'b1;
        #1;
        total++;
        if (read_data !== 32'd9) begin bad++; $display("FAIL dec_rw_pre_edge got=%h exp=%h", read_data, 32'd9); end
        @(posedge clk); #1;
        total++;
        if (read_data !== 32'd5) begin bad++; $display("FAIL dec_rw_post_edge got=%h exp=%h", read_data, 32'd5); end
        mem_write = 1'b0; mem_read = 1'b0; addr = '0; write_data = '0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_div_zero();
        test_overflow();
        test_mid_frame_reset();
        test_decode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
